skip_sync_if: RTL and testbench
===============================

Name: skip_sync_if

Overview:
- Parametrised successor of the two-operand skip/thru interface used for index compression in front of an ALU.
- Accepts NUM_SRC source token streams and their shared-data tokens, and re-aligns them in per-source FIFOs, because DReg retiming does not guarantee operand alignment.
- Classifies each aligned operand group as compute, skip, thru or remove, and issues the result through a registered output stage with downstream back-pressure.

Parameters:
- NUM_SRC, 2, number of source operand channels (2..8)
- WIDTH_DATA, 32, data width of FTk_t.d
- DEPTH_FIFO, 4, entries per source FIFO (power of 2, >=2)
- SKIPVAL, 32'h0, data value that triggers skip
- THRUVAL, 32'h1, data value that triggers thru
- RESERVE, 32'h0, data value placed in reserve tokens
- WIDTH_CNT, 16, width of the statistics counters

Ports:
- clock, in, 1, system clock
- reset, in, 1, asynchronous active-low reset
- I_En, in, 1, enables detection; 0 forces compute classification
- I_Mode, in, 2, 00 none, 01 skip only, 10 thru only, 11 skip+thru; sampled per group at issue
- I_FTk, in, NUM_SRC x FTk_t, source data tokens
- I_SFTk, in, NUM_SRC x FTk_t, shared data tokens, paired with I_FTk on the same cycle
- O_Full, out, NUM_SRC, per-source FIFO full (upstream must hold its token)
- I_Rdy, in, 1, downstream accepts the output stage this cycle
- O_FTk, out, NUM_SRC x FTk_t, operands to ALU logic
- O_Fired, out, 1, compute group valid
- O_TS, out, 1, thru/skip group valid
- O_TSFTk, out, NUM_SRC x FTk_t, thru/skip tokens to the output buffer
- O_SkipCnt, out, WIDTH_CNT, skipped-group count (feature only)
- O_ThruCnt, out, WIDTH_CNT, thru-group count (feature only)

Behaviour:
- Reset: all FIFOs empty, O_Full=0, output stage EMPTY, all outputs '0, counters 0. Asserting reset mid-group discards the group.
- Enqueue: when I_FTk[k].v & ~O_Full[k], store {I_FTk[k], I_SFTk[k].d, I_SFTk[k].v}. Tokens presented while full are ignored.
- Group ready: all NUM_SRC FIFO heads are valid.
- Classification (combinational on heads):
  - EqSkip[k] = head.d==SKIPVAL & shared.v & I_En & Mode[0]
  - EqShare[k] = head.d==shared.d & shared.v & I_En
  - EqThru[k] = head.d==THRUVAL & I_En & Mode[1]
  - Rel = AND of head.r over all k
- Priority: Rel → compute. Else any (EqSkip&EqShare) → REMOVE. Else any EqThru → THRU. Else any EqSkip → SKIP. Else compute.
- THRU: the lowest-index EqThru channel t gets O_TSFTk[t]=head[t]. Every other channel gets the zero token (v=1, all other fields 0).
- SKIP: each EqSkip channel gets a reserve token (v=1, a=0, c=0, r=0, i=head[0].i, d=RESERVE). Other channels get '0.
- REMOVE: group is consumed with no output and no valid flag.
- Output stage FSM, EMPTY/HOLD:
  - EMPTY & group ready: pop all heads together, load registers, go to HOLD; REMOVE instead pops and stays EMPTY.
  - HOLD & I_Rdy: if a group is ready it loads back-to-back (stay HOLD); otherwise go to EMPTY.
  - HOLD & ~I_Rdy: all outputs held stable; no pop.
- Outputs in HOLD: compute sets O_FTk=heads and O_Fired=1, with O_TS=0 and O_TSFTk='0. Thru/skip sets O_TS=1 and O_TSFTk per the rules above, with O_FTk='0 and O_Fired=0. O_Fired and O_TS are never both 1.
- Latency: 1 cycle from group ready to output valid. Throughput is 1 group per cycle.
- Simultaneous enqueue and pop on a full FIFO is allowed: O_Full stays high and the count is unchanged.
- FIFO pointers wrap modulo DEPTH_FIFO. Count is held in clog2(DEPTH_FIFO)+1 bits.

Optional Feature:
- SKIP_IF_STAT_EN defined: O_SkipCnt increments when a SKIP or REMOVE group loads or pops; O_ThruCnt increments when a THRU group loads. Both saturate at all-ones.
- SKIP_IF_STAT_EN undefined: both ports are tied to '0 and no counter flops exist.

Decomposition:
- pkg_extend_index gains:
  - enum tsclass_t {TS_COMP, TS_SKIP, TS_THRU, TS_REMOVE}
  - struct skip_ent_t {FTk_t tk; logic sv; logic [WIDTH_DATA-1:0] sd}
  - constant ZERO_TK
- FTk_t is taken from pkg_en.
- One sub-module: skip_sync_fifo, a single-source FIFO of skip_ent_t instantiated NUM_SRC times.
- Classification and the FSM stay in the top module.

Test Plan:
- NUM_SRC=2, Mode=11, A=5, B=7 in the same cycle, I_Rdy=1 → next cycle O_Fired=1, O_FTk={5,7}, O_TS=0.
- A=0 with shared A=3, B=9 → O_TS=1, O_TSFTk[0].d=RESERVE, O_TSFTk[1]='0, O_FTk='0; SkipCnt=1 with the feature defined.
- A=0 with shared A=0 → no output, FIFOs popped, O_TS=O_Fired=0, SkipCnt=1.
- B=1 (thru), A=4 → O_TSFTk[1]=head B, O_TSFTk[0]=zero token with v=1; ThruCnt=1.
- Misalignment with back-pressure:
  - Drive A for 4 cycles with B idle → O_Full[0]=1 and no output.
  - Then drive B while holding I_Rdy=0 → one group is held stable.
  - Then release I_Rdy → 4 groups issue in order, one per cycle.
- Assert reset while in HOLD with 2 entries queued → outputs 0 immediately, FIFOs empty; a fresh group after reset issues normally.

Source files
------------

// File: rtl/skip_sync_if_pkg.sv
// Token type and skip/thru interface types shared by skip_sync_if and its per-source FIFO.
package pkg_en;
    localparam int unsigned WIDTH_DATA = 32;
    localparam int unsigned WIDTH_IDX  = 8;

    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  c;
        logic                  r;
        logic [WIDTH_IDX-1:0]  i;
        logic [WIDTH_DATA-1:0] d;
    } FTk_t;
endpackage

package skip_sync_if_pkg;
    import pkg_en::*;

    typedef enum logic [1:0] {TS_COMP, TS_SKIP, TS_THRU, TS_REMOVE} tsclass_t;

    typedef enum logic {ST_EMPTY, ST_HOLD} ostate_t;

    typedef struct packed {
        FTk_t                  tk;
        logic                  sv;
        logic [WIDTH_DATA-1:0] sd;
    } skip_ent_t;

    // Filler token for non-selected channels of a thru group.
    localparam FTk_t ZERO_TK = '{v: 1'b1, a: 1'b0, c: 1'b0, r: 1'b0, i: '0, d: '0};
endpackage

// File: rtl/skip_sync_fifo.sv
// Single-source re-alignment FIFO of token + shared-data entries.
module skip_sync_fifo
    import skip_sync_if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  skip_ent_t din,
    input  logic      pop,
    output skip_ent_t head,
    output logic      head_v,
    output logic      full
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    skip_ent_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still takes a write in the cycle its head is popped.
    assign do_pop  = pop & head_v;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        cnt_nxt = cnt;
        if (do_push && !do_pop) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head_v <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt    <= cnt_nxt;
            head_v <= (cnt_nxt != '0);
            full   <= (cnt_nxt == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/skip_sync_if.sv
// Multi-source skip/thru interface: aligns source tokens, classifies each group, issues via a held output stage.
// Optional statistics counters are built when SKIP_IF_STAT_EN is defined.
module skip_sync_if
    import pkg_en::*;
    import skip_sync_if_pkg::*;
#(
    parameter int unsigned          NUM_SRC    = 2,
    parameter int unsigned          DEPTH_FIFO = 4,
    parameter logic [WIDTH_DATA-1:0] SKIPVAL   = WIDTH_DATA'(32'h0),
    parameter logic [WIDTH_DATA-1:0] THRUVAL   = WIDTH_DATA'(32'h1),
    parameter logic [WIDTH_DATA-1:0] RESERVE   = WIDTH_DATA'(32'h0),
    parameter int unsigned          WIDTH_CNT  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      I_En,
    input  logic [1:0]                I_Mode,
    input  FTk_t [NUM_SRC-1:0]        I_FTk,
    input  FTk_t [NUM_SRC-1:0]        I_SFTk,
    output logic [NUM_SRC-1:0]        O_Full,
    input  logic                      I_Rdy,
    output FTk_t [NUM_SRC-1:0]        O_FTk,
    output logic                      O_Fired,
    output logic                      O_TS,
    output FTk_t [NUM_SRC-1:0]        O_TSFTk,
    output logic [WIDTH_CNT-1:0]      O_SkipCnt,
    output logic [WIDTH_CNT-1:0]      O_ThruCnt
);
    skip_ent_t          head [NUM_SRC];
    skip_ent_t          ent_in [NUM_SRC];
    logic [NUM_SRC-1:0] head_v;
    FTk_t [NUM_SRC-1:0] head_tk;
    FTk_t [NUM_SRC-1:0] ts_tk;
    logic [NUM_SRC-1:0] eq_skip;
    logic [NUM_SRC-1:0] eq_share;
    logic [NUM_SRC-1:0] eq_thru;
    logic               rel;
    logic               thru_found;
    logic               group_rdy;
    logic               pop;
    tsclass_t           cls;
    ostate_t            state;
    logic               unused_sftk;

    // Only the shared token's valid and data travel with the entry.
    assign unused_sftk = ^I_SFTk;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign ent_in[k] = '{tk: I_FTk[k], sv: I_SFTk[k].v, sd: I_SFTk[k].d};

        skip_sync_fifo #(.DEPTH(DEPTH_FIFO)) u_fifo (
            .clock  (clock),
            .reset  (reset),
            .push   (I_FTk[k].v),
            .din    (ent_in[k]),
            .pop    (pop),
            .head   (head[k]),
            .head_v (head_v[k]),
            .full   (O_Full[k])
        );

        assign head_tk[k] = head[k].tk;
    end

    assign group_rdy = &head_v;
    assign pop       = group_rdy & ((state == ST_EMPTY) | I_Rdy);

    // Classify the aligned head group and build the thru/skip token set.
    always_comb begin
        eq_skip    = '0;
        eq_share   = '0;
        eq_thru    = '0;
        ts_tk      = '0;
        thru_found = 1'b0;
        cls        = TS_COMP;
        rel        = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            eq_skip[k]  = (head[k].tk.d == SKIPVAL) & head[k].sv & I_En & I_Mode[0];
            eq_share[k] = (head[k].tk.d == head[k].sd) & head[k].sv & I_En;
            eq_thru[k]  = (head[k].tk.d == THRUVAL) & I_En & I_Mode[1];
            rel         = rel & head[k].tk.r;
        end
        if (!rel) begin
            if (|(eq_skip & eq_share)) cls = TS_REMOVE;
            else if (|eq_thru)         cls = TS_THRU;
            else if (|eq_skip)         cls = TS_SKIP;
        end
        if (cls == TS_THRU) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (eq_thru[k] && !thru_found) begin
                    ts_tk[k]   = head[k].tk;
                    thru_found = 1'b1;
                end else begin
                    ts_tk[k] = ZERO_TK;
                end
            end
        end else if (cls == TS_SKIP) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (eq_skip[k]) begin
                    ts_tk[k] = '{v: 1'b1, a: 1'b0, c: 1'b0, r: 1'b0,
                                 i: head[0].tk.i, d: RESERVE};
                end
            end
        end
    end

    // Output stage: EMPTY/HOLD with registered outputs held under back-pressure.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_EMPTY;
            O_FTk   <= '0;
            O_Fired <= 1'b0;
            O_TS    <= 1'b0;
            O_TSFTk <= '0;
        end else if (state == ST_EMPTY || I_Rdy) begin
            if (pop && cls != TS_REMOVE) begin
                state <= ST_HOLD;
                if (cls == TS_COMP) begin
                    O_FTk   <= head_tk;
                    O_Fired <= 1'b1;
                    O_TS    <= 1'b0;
                    O_TSFTk <= '0;
                end else begin
                    O_FTk   <= '0;
                    O_Fired <= 1'b0;
                    O_TS    <= 1'b1;
                    O_TSFTk <= ts_tk;
                end
            end else begin
                state   <= ST_EMPTY;
                O_FTk   <= '0;
                O_Fired <= 1'b0;
                O_TS    <= 1'b0;
                O_TSFTk <= '0;
            end
        end
    end

`ifdef SKIP_IF_STAT_EN
    // Saturating group statistics.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            O_SkipCnt <= '0;
            O_ThruCnt <= '0;
        end else if (pop) begin
            if ((cls == TS_SKIP || cls == TS_REMOVE) && !(&O_SkipCnt)) begin
                O_SkipCnt <= O_SkipCnt + WIDTH_CNT'(1);
            end
            if (cls == TS_THRU && !(&O_ThruCnt)) begin
                O_ThruCnt <= O_ThruCnt + WIDTH_CNT'(1);
            end
        end
    end
`else
    assign O_SkipCnt = '0;
    assign O_ThruCnt = '0;
`endif
endmodule

// File: tb/tb_skip_sync_if.sv
// Directed bench for skip_sync_if (NUM_SRC=2, defaults); honours SKIP_IF_STAT_EN for counter expectations.
module tb_skip_sync_if;
    import pkg_en::*;
    import skip_sync_if_pkg::*;

    logic          clock = 1'b0;
    logic          reset;
    logic          I_En;
    logic [1:0]    I_Mode;
    FTk_t [1:0]    I_FTk;
    FTk_t [1:0]    I_SFTk;
    logic [1:0]    O_Full;
    logic          I_Rdy;
    FTk_t [1:0]    O_FTk;
    logic          O_Fired;
    logic          O_TS;
    FTk_t [1:0]    O_TSFTk;
    logic [15:0]   O_SkipCnt;
    logic [15:0]   O_ThruCnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_skip = 0;
    int exp_thru = 0;
    FTk_t [1:0] e;

    skip_sync_if dut (
        .clock     (clock),
        .reset     (reset),
        .I_En      (I_En),
        .I_Mode    (I_Mode),
        .I_FTk     (I_FTk),
        .I_SFTk    (I_SFTk),
        .O_Full    (O_Full),
        .I_Rdy     (I_Rdy),
        .O_FTk     (O_FTk),
        .O_Fired   (O_Fired),
        .O_TS      (O_TS),
        .O_TSFTk   (O_TSFTk),
        .O_SkipCnt (O_SkipCnt),
        .O_ThruCnt (O_ThruCnt)
    );

    always #5 clock = ~clock;

    function automatic FTk_t mk(input logic [7:0] i, input logic [31:0] d, input logic r);
        return '{v: 1'b1, a: 1'b0, c: 1'b0, r: r, i: i, d: d};
    endfunction

    function automatic FTk_t sh(input logic [31:0] d);
        return '{v: 1'b1, a: 1'b0, c: 1'b0, r: 1'b0, i: 8'h00, d: d};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        I_FTk  = '0;
        I_SFTk = '0;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef SKIP_IF_STAT_EN
        chk({tag, "_skipcnt"}, 128'(O_SkipCnt), 128'(exp_skip));
        chk({tag, "_thrucnt"}, 128'(O_ThruCnt), 128'(exp_thru));
`else
        chk({tag, "_skipcnt"}, 128'(O_SkipCnt), 128'(0));
        chk({tag, "_thrucnt"}, 128'(O_ThruCnt), 128'(0));
`endif
    endtask

    initial begin
        reset  = 1'b0;
        I_En   = 1'b1;
        I_Mode = 2'b11;
        I_Rdy  = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_fired", 128'(O_Fired), 128'(0));
        chk("rst_ts", 128'(O_TS), 128'(0));
        chk("rst_full", 128'(O_Full), 128'(0));
        chk("rst_ftk", 128'(O_FTk), 128'(0));
        chk_cnt("rst");
        reset = 1'b1;
        tick();

        // compute group
        I_FTk[0] = mk(8'h01, 32'd5, 1'b0);
        I_FTk[1] = mk(8'h02, 32'd7, 1'b0);
        tick();
        idle();
        chk("comp_not_yet", 128'(O_Fired), 128'(0));
        tick();
        e[0] = mk(8'h01, 32'd5, 1'b0);
        e[1] = mk(8'h02, 32'd7, 1'b0);
        chk("comp_fired", 128'(O_Fired), 128'(1));
        chk("comp_ts", 128'(O_TS), 128'(0));
        chk("comp_ftk", 128'(O_FTk), 128'(e));
        chk("comp_tsftk", 128'(O_TSFTk), 128'(0));
        tick();
        chk("comp_drain", 128'(O_Fired), 128'(0));

        // skip group
        I_FTk[0]  = mk(8'h3C, 32'd0, 1'b0);
        I_SFTk[0] = sh(32'd3);
        I_FTk[1]  = mk(8'h05, 32'd9, 1'b0);
        tick();
        idle();
        tick();
        exp_skip++;
        e[0] = '{v: 1'b1, a: 1'b0, c: 1'b0, r: 1'b0, i: 8'h3C, d: 32'h0};
        e[1] = '0;
        chk("skip_ts", 128'(O_TS), 128'(1));
        chk("skip_fired", 128'(O_Fired), 128'(0));
        chk("skip_tsftk", 128'(O_TSFTk), 128'(e));
        chk("skip_ftk", 128'(O_FTk), 128'(0));
        chk_cnt("skip");
        tick();

        // remove group
        I_FTk[0]  = mk(8'h11, 32'd0, 1'b0);
        I_SFTk[0] = sh(32'd0);
        I_FTk[1]  = mk(8'h12, 32'd6, 1'b0);
        tick();
        idle();
        tick();
        exp_skip++;
        chk("rem_ts", 128'(O_TS), 128'(0));
        chk("rem_fired", 128'(O_Fired), 128'(0));
        chk_cnt("rem");
        tick();

        // thru group on channel 1
        I_FTk[0] = mk(8'h21, 32'd4, 1'b0);
        I_FTk[1] = mk(8'h07, 32'd1, 1'b0);
        tick();
        idle();
        tick();
        exp_thru++;
        e[0] = '{v: 1'b1, a: 1'b0, c: 1'b0, r: 1'b0, i: 8'h00, d: 32'h0};
        e[1] = mk(8'h07, 32'd1, 1'b0);
        chk("thru_ts", 128'(O_TS), 128'(1));
        chk("thru_fired", 128'(O_Fired), 128'(0));
        chk("thru_tsftk", 128'(O_TSFTk), 128'(e));
        chk_cnt("thru");
        tick();

        // detection disabled: would-be remove group computes
        I_En      = 1'b0;
        I_FTk[0]  = mk(8'h31, 32'd0, 1'b0);
        I_SFTk[0] = sh(32'd0);
        I_FTk[1]  = mk(8'h32, 32'd1, 1'b0);
        tick();
        idle();
        tick();
        e[0] = mk(8'h31, 32'd0, 1'b0);
        e[1] = mk(8'h32, 32'd1, 1'b0);
        chk("en0_fired", 128'(O_Fired), 128'(1));
        chk("en0_ftk", 128'(O_FTk), 128'(e));
        I_En = 1'b1;
        tick();

        // mode 01 disables thru
        I_Mode   = 2'b01;
        I_FTk[0] = mk(8'h41, 32'd8, 1'b0);
        I_FTk[1] = mk(8'h42, 32'd1, 1'b0);
        tick();
        idle();
        tick();
        chk("mode01_fired", 128'(O_Fired), 128'(1));
        chk("mode01_ts", 128'(O_TS), 128'(0));
        I_Mode = 2'b11;
        tick();

        // all-reserve group computes even with a skip value
        I_FTk[0]  = mk(8'h51, 32'd0, 1'b1);
        I_SFTk[0] = sh(32'd0);
        I_FTk[1]  = mk(8'h52, 32'd5, 1'b1);
        tick();
        idle();
        tick();
        e[0] = mk(8'h51, 32'd0, 1'b1);
        e[1] = mk(8'h52, 32'd5, 1'b1);
        chk("rel_fired", 128'(O_Fired), 128'(1));
        chk("rel_ftk", 128'(O_FTk), 128'(e));
        chk_cnt("rel");
        tick();

        // misalignment: fill A, then B under back-pressure
        I_Rdy = 1'b0;
        for (int j = 0; j < 4; j++) begin
            I_FTk[0] = mk(8'h60, 32'(10 + j), 1'b0);
            tick();
        end
        idle();
        chk("mis_full", 128'(O_Full), 128'(2'b01));
        chk("mis_nofire", 128'(O_Fired), 128'(0));
        e[0] = mk(8'h60, 32'd10, 1'b0);
        e[1] = mk(8'h70, 32'd20, 1'b0);
        for (int j = 0; j < 4; j++) begin
            I_FTk[1] = mk(8'h70, 32'(20 + j), 1'b0);
            tick();
            if (j >= 1) begin
                chk("mis_hold_fired", 128'(O_Fired), 128'(1));
                chk("mis_hold_ftk", 128'(O_FTk), 128'(e));
            end
        end
        idle();
        tick();
        chk("mis_hold_last", 128'(O_FTk), 128'(e));
        I_Rdy = 1'b1;
        for (int j = 1; j < 4; j++) begin
            tick();
            e[0] = mk(8'h60, 32'(10 + j), 1'b0);
            e[1] = mk(8'h70, 32'(20 + j), 1'b0);
            chk("mis_issue_fired", 128'(O_Fired), 128'(1));
            chk("mis_issue_ftk", 128'(O_FTk), 128'(e));
        end
        tick();
        chk("mis_drained", 128'(O_Fired), 128'(0));

        // reset while holding with two groups queued
        I_Rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            I_FTk[0] = mk(8'h80, 32'(30 + j), 1'b0);
            I_FTk[1] = mk(8'h90, 32'(30 + j), 1'b0);
            tick();
        end
        idle();
        e[0] = mk(8'h80, 32'd30, 1'b0);
        e[1] = mk(8'h90, 32'd30, 1'b0);
        chk("pre_rst_ftk", 128'(O_FTk), 128'(e));
        reset = 1'b0;
        #1;
        chk("mid_rst_fired", 128'(O_Fired), 128'(0));
        chk("mid_rst_ftk", 128'(O_FTk), 128'(0));
        chk("mid_rst_full", 128'(O_Full), 128'(0));
        exp_skip = 0;
        exp_thru = 0;
        chk_cnt("mid_rst");
        tick();
        reset = 1'b1;
        I_Rdy = 1'b1;
        tick();
        chk("post_rst_empty", 128'(O_Fired), 128'(0));
        I_FTk[0] = mk(8'hA0, 32'd40, 1'b0);
        I_FTk[1] = mk(8'hA1, 32'd41, 1'b0);
        tick();
        idle();
        tick();
        e[0] = mk(8'hA0, 32'd40, 1'b0);
        e[1] = mk(8'hA1, 32'd41, 1'b0);
        chk("post_rst_fired", 128'(O_Fired), 128'(1));
        chk("post_rst_ftk", 128'(O_FTk), 128'(e));
        tick();
        chk("post_rst_drain", 128'(O_Fired), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
